// File: rtl/cp0_exception_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes,
// EXCE bundle layout and sequencer state encoding.
package cp0_exception_ctrl_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LSB = 10;
    localparam int ST_IM_MSB = 15;

    // Only IE, EXL and the hardware interrupt mask bits hold state.
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FC03;

    localparam int CAUSE_SWIP_LSB = 8;
    localparam int CAUSE_SWIP_MSB = 9;
    localparam int IP_LSB         = 8;
    localparam int IP_MSB         = 15;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;

    localparam int EXCE_MFC0 = 34;
    localparam int EXCE_MTC0 = 33;
    localparam int EXCE_ERET = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTRY  = 2'd1,
        S_RETURN = 2'd2,
        S_VECTOR = 2'd3
    } cp0_state_e;

    // Lowest set exception bit wins; syscall is bit 1, anything above is treated as RI.
    function automatic logic [4:0] exc_code_of(input logic [31:1] exc_bits);
        logic [4:0] code;
        logic       found;
        code  = EXC_INT;
        found = 1'b0;
        for (int b = 1; b < 32; b++) begin
            if (exc_bits[b] && !found) begin
                found = 1'b1;
                code  = (b == 1) ? EXC_SYS : EXC_RI;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Per-bit multi-flop synchronizer for the asynchronous hardware interrupt lines.
module cp0_int_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/cp0_exception_ctrl.sv
// Coprocessor-0 exception/interrupt sequencer at commit: owns Status/Cause/EPC,
// flushes and stalls the pipeline and hands a redirect target to fetch.
module cp0_exception_ctrl
    import cp0_exception_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
    parameter int          NUM_HW_INT   = 6,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  commit_valid,
    input  logic [34:0]           exce_i,
    input  logic [31:0]           commit_pc,
    input  logic [4:0]            cp0_sel,
    input  logic [31:0]           cp0_wdata,
    input  logic [NUM_HW_INT-1:0] hw_int,
    output logic [31:0]           cp0_rdata,
    output logic                  flush,
    output logic                  stall,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    input  logic                  redirect_ready,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);

    cp0_state_e            state;
    logic [31:0]           status_q;
    logic [31:0]           epc_q;
    logic [1:0]            sw_ip_q;
    logic [4:0]            exc_code_q;
    logic [NUM_HW_INT-1:0] hw_sync;
    logic [5:0]            hw_ip;
    logic [7:0]            pending_ip;
    logic                  idle;
    logic                  exc_hit;
    logic                  int_hit;
    logic                  eret_hit;
    logic                  take_entry;
    logic                  take_return;
    logic                  do_mtc0;
    logic [4:0]            entry_code;
    logic                  unused_bits;

    cp0_int_sync #(
        .WIDTH  (NUM_HW_INT),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (hw_int),
        .sync_out (hw_sync)
    );

    // The mfc0 flag only matters to the decoder; bit 0 of INT32 is reserved.
    assign unused_bits = exce_i[EXCE_MFC0] ^ exce_i[0];

    assign hw_ip    = 6'(hw_sync);
    assign status_o = status_q;
    assign cause_o  = {16'h0000, hw_ip, sw_ip_q, 1'b0, exc_code_q, 2'b00};
    assign epc_o    = epc_q;

    always_comb begin
        cp0_rdata = '0;
        case (cp0_sel)
            CP0_STATUS: cp0_rdata = status_q;
            CP0_CAUSE:  cp0_rdata = cause_o;
            CP0_EPC:    cp0_rdata = epc_q;
            default:    cp0_rdata = '0;
        endcase
    end

    // Trigger decode sees the registers as they were before this commit's mtc0.
    always_comb begin
        idle        = (state == S_IDLE);
        pending_ip  = cause_o[IP_MSB:IP_LSB] & status_q[IP_MSB:IP_LSB];
        exc_hit     = |exce_i[31:1];
        int_hit     = status_q[ST_IE] & ~status_q[ST_EXL] & (|pending_ip);
        eret_hit    = exce_i[EXCE_ERET];
        take_entry  = idle & commit_valid & (exc_hit | int_hit);
        take_return = idle & commit_valid & ~exc_hit & ~int_hit & eret_hit;
        entry_code  = exc_hit ? exc_code_of(exce_i[31:1]) : EXC_INT;
        do_mtc0     = idle & commit_valid & exce_i[EXCE_MTC0] & ~take_entry & ~take_return;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= '0;
            sw_ip_q    <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else if (take_entry) begin
            // A nested exception keeps the original return address.
            if (!status_q[ST_EXL]) begin
                epc_q <= commit_pc;
            end
            exc_code_q       <= entry_code;
            status_q[ST_EXL] <= 1'b1;
        end else if (take_return) begin
            status_q[ST_EXL] <= 1'b0;
        end else if (do_mtc0) begin
            case (cp0_sel)
                CP0_STATUS: status_q <= cp0_wdata & STATUS_WMASK;
                CP0_CAUSE:  sw_ip_q  <= cp0_wdata[CAUSE_SWIP_MSB:CAUSE_SWIP_LSB];
                CP0_EPC:    epc_q    <= cp0_wdata;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            flush          <= 1'b0;
            stall          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take_entry) begin
                        state <= S_ENTRY;
                        flush <= 1'b1;
                        stall <= 1'b1;
                    end else if (take_return) begin
                        state <= S_RETURN;
                        flush <= 1'b1;
                        stall <= 1'b1;
                    end
                end
                S_ENTRY, S_RETURN: begin
                    // EPC cannot change outside IDLE, so it still holds the return target.
                    state          <= S_VECTOR;
                    flush          <= 1'b0;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= (state == S_ENTRY) ? HANDLER_ADDR : epc_q;
                end
                S_VECTOR: begin
                    if (redirect_ready) begin
                        state          <= S_IDLE;
                        stall          <= 1'b0;
                        redirect_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Bench for cp0_exception_ctrl: directed scenarios then random traffic, all
// checked every cycle against a behavioural model of the CP0 rules.
module tb_cp0_exception_ctrl;

    localparam logic [31:0] HANDLER = 32'h8000_0180;
    localparam int          NHW     = 6;
    localparam int          SYNC    = 2;
    localparam logic [34:0] MTC0    = 35'h2_0000_0000;
    localparam logic [34:0] ERET    = 35'h1_0000_0000;
    localparam logic [34:0] MFC0    = 35'h4_0000_0000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           commit_valid = 1'b0;
    logic [34:0]    exce = '0;
    logic [31:0]    commit_pc = '0;
    logic [4:0]     cp0_sel = '0;
    logic [31:0]    cp0_wdata = '0;
    logic [NHW-1:0] hw_int = '0;
    logic           redirect_ready = 1'b0;
    logic [31:0]    cp0_rdata, redirect_pc, status_o, cause_o, epc_o;
    logic           flush, stall, redirect_valid;

    cp0_exception_ctrl #(
        .HANDLER_ADDR (HANDLER),
        .NUM_HW_INT   (NHW),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .commit_valid   (commit_valid),
        .exce_i         (exce),
        .commit_pc      (commit_pc),
        .cp0_sel        (cp0_sel),
        .cp0_wdata      (cp0_wdata),
        .hw_int         (hw_int),
        .cp0_rdata      (cp0_rdata),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Architectural model: named fields, a sequence countdown and a history of hw_int samples.
    logic           m_ie, m_exl;
    logic [5:0]     m_im;
    logic [1:0]     m_swip;
    logic [4:0]     m_code;
    logic [31:0]    m_epc;
    int             m_flush_left;
    bit             m_redir;
    logic [31:0]    m_target;
    logic [NHW-1:0] hist[$];

    function automatic logic [31:0] m_status();
        return {16'h0000, m_im, 8'h00, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(hist[0]) << 10) | (32'(m_swip) << 8) | (32'(m_code) << 2);
    endfunction

    function automatic logic [31:0] m_reg(input logic [4:0] sel);
        if (sel == 5'd12) return m_status();
        if (sel == 5'd13) return m_cause();
        if (sel == 5'd14) return m_epc;
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_im = '0; m_swip = '0; m_code = '0; m_epc = '0;
        m_flush_left = 0; m_redir = 0; m_target = '0;
        hist.delete();
        repeat (SYNC) hist.push_back('0);
    endtask

    task automatic model_edge();
        logic [7:0] ip;
        bit exc, irq;
        if (!rst_n) return;
        ip = {6'(hist[0]), m_swip};
        if (m_flush_left > 0) begin
            m_flush_left--;
            m_redir = 1;
        end else if (m_redir) begin
            if (redirect_ready) m_redir = 0;
        end else if (commit_valid) begin
            exc = (exce[31:1] != 0);
            irq = m_ie && !m_exl && ((ip & {m_im, 2'b00}) != 0);
            if (exc || irq) begin
                if (!m_exl) m_epc = commit_pc;
                m_code = !exc ? 5'd0 : (exce[1] ? 5'd8 : 5'd10);
                m_exl = 1; m_flush_left = 1; m_target = HANDLER;
            end else if (exce[32]) begin
                m_exl = 0; m_flush_left = 1; m_target = m_epc;
            end else if (exce[33]) begin
                case (cp0_sel)
                    5'd12: begin m_im = cp0_wdata[15:10]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0]; end
                    5'd13: m_swip = cp0_wdata[9:8];
                    5'd14: m_epc = cp0_wdata;
                    default: ;
                endcase
            end
        end
        hist.push_back(hw_int);
        void'(hist.pop_front());
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("flush", 32'(flush), 32'(m_flush_left > 0));
        chk("stall", 32'(stall), 32'(m_flush_left > 0 || m_redir));
        chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
        if (m_redir) chk("redirect_pc", redirect_pc, m_target);
        chk("status", status_o, m_status());
        chk("cause", cause_o, m_cause());
        chk("epc", epc_o, m_epc);
        chk("cp0_rdata", cp0_rdata, m_reg(cp0_sel));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic commit(input logic [34:0] e, input logic [31:0] pc,
                          input logic [4:0] sel, input logic [31:0] wd);
        commit_valid = 1; exce = e; commit_pc = pc; cp0_sel = sel; cp0_wdata = wd;
        cycle();
        commit_valid = 0; exce = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (m_flush_left > 0 || m_redir); i++) cycle();
        chk("drain_timeout", 32'(m_flush_left > 0 || m_redir), 32'd0);
    endtask

    task automatic reset_now();
        rst_n = 0;
        model_reset();
        #1;
        check_all();
        chk("reset_redirect_pc", redirect_pc, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [34:0] e;
        int r;

        // Power-on reset
        reset_now();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        redirect_ready = 1;

        // Syscall
        commit(35'h2, 32'h400, 5'd14, 32'h0);
        chk("sys_flush", 32'(flush), 32'd1);
        chk("sys_epc", epc_o, 32'h400);
        chk("sys_code", 32'(cause_o[6:2]), 32'd8);
        chk("sys_exl", 32'(status_o[1]), 32'd1);
        cycle();
        chk("sys_rv", 32'(redirect_valid), 32'd1);
        chk("sys_rpc", redirect_pc, HANDLER);
        chk("sys_flush_done", 32'(flush), 32'd0);
        cycle();
        chk("sys_accepted", 32'(redirect_valid), 32'd0);

        // Reserved instruction nested under EXL, fetch back-pressure for 3 cycles
        redirect_ready = 0;
        commit(35'h4, 32'h600, 5'd13, 32'h0);
        chk("ri_code", 32'(cause_o[6:2]), 32'd10);
        chk("ri_nested_epc", epc_o, 32'h400);
        cycle();
        repeat (3) begin
            cycle();
            chk("ri_hold_rv", 32'(redirect_valid), 32'd1);
            chk("ri_hold_rpc", redirect_pc, HANDLER);
        end
        redirect_ready = 1;
        cycle();
        chk("ri_accepted", 32'(redirect_valid), 32'd0);

        // ERET to a software-written EPC
        commit(MTC0, 32'h700, 5'd14, 32'h504);
        chk("mtc0_epc", epc_o, 32'h504);
        commit(ERET, 32'h710, 5'd12, 32'h0);
        chk("eret_exl", 32'(status_o[1]), 32'd0);
        chk("eret_flush", 32'(flush), 32'd1);
        cycle();
        chk("eret_rpc", redirect_pc, 32'h504);
        cycle();

        // Hardware interrupt after the synchronizer delay
        commit(MTC0, 32'h720, 5'd12, 32'h0000_0401);
        chk("status_401", status_o, 32'h0000_0401);
        hw_int = 6'b000001;
        repeat (SYNC) cycle();
        chk("ip_synced", 32'(cause_o[10]), 32'd1);
        commit(35'h0, 32'h500, 5'd13, 32'h0);
        chk("int_flush", 32'(flush), 32'd1);
        chk("int_epc", epc_o, 32'h500);
        chk("int_code", 32'(cause_o[6:2]), 32'd0);
        drain();

        // EXL masks the still-pending interrupt
        commit(35'h0, 32'h510, 5'd14, 32'h0);
        chk("exl_mask", 32'(flush), 32'd0);
        commit(MTC0, 32'h520, 5'd12, 32'h0000_0001);
        // IM=0 masks it as well
        commit(35'h0, 32'h530, 5'd12, 32'h0);
        chk("im_mask", 32'(flush), 32'd0);
        // Unmasking mtc0 does not trigger itself, the next commit does
        commit(MTC0, 32'h540, 5'd12, 32'h0000_0401);
        chk("same_cycle_unmask", 32'(flush), 32'd0);
        commit(MFC0, 32'h550, 5'd12, 32'h0);
        chk("unmask_trigger", 32'(flush), 32'd1);
        chk("unmask_epc", epc_o, 32'h550);
        drain();

        // Reset while the redirect is waiting
        hw_int = '0;
        redirect_ready = 0;
        commit(35'h2, 32'h800, 5'd14, 32'h0);
        cycle();
        chk("vec_rv", 32'(redirect_valid), 32'd1);
        #2;
        reset_now();
        cp0_sel = 5'd13; #1; chk("rst_rd_cause", cp0_rdata, 32'h0);
        cp0_sel = 5'd14; #1; chk("rst_rd_epc", cp0_rdata, 32'h0);
        cp0_sel = 5'd7;  #1; chk("rst_rd_other", cp0_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1;

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            commit_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 15);
            e = '0;
            if (r < 2) e[1] = 1'b1;
            else if (r == 2) e[2] = 1'b1;
            else if (r < 5) e[32] = 1'b1;
            if ($urandom_range(0, 2) == 0) e[33] = 1'b1;
            if ($urandom_range(0, 3) == 0) e[34] = 1'b1;
            if ($urandom_range(0, 1) == 0) e[0] = 1'b1;
            exce = e;
            commit_pc = $urandom & 32'hFFFF_FFFC;
            case ($urandom_range(0, 3))
                0: cp0_sel = 5'd12;
                1: cp0_sel = 5'd13;
                2: cp0_sel = 5'd14;
                default: cp0_sel = 5'($urandom);
            endcase
            cp0_wdata = $urandom;
            if ($urandom_range(0, 7) == 0) hw_int = NHW'($urandom);
            redirect_ready = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
